// File: rtl/tail_sum_pkg.sv
// tail_sum_pkg: FSM encoding, config field positions and default buffer depth
// shared by the tail-sum decoder and its packet buffer.
package tail_sum_pkg;
    typedef enum logic {RECV = 1'b0, SEND = 1'b1} state_e;
    localparam int CFG_LEN_MSB = 15;
    localparam int CFG_LEN_LSB = 8;
    localparam int CFG_K_MSB   = 7;
    localparam int CFG_K_LSB   = 0;
    localparam int DEF_DEPTH   = 256;
endpackage

// File: rtl/tsd_pkt_buf.sv
// tsd_pkt_buf: DEPTH x 8 packet store with one synchronous write port and
// two combinational read ports (head byte and matching tail byte).
module tsd_pkt_buf
    import tail_sum_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [7:0]    rdata_a,
    output logic [7:0]    rdata_b
);
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];
endmodule

// File: rtl/tail_sum_decoder.sv
// tail_sum_decoder: store-and-forward AXI-Stream decoder; buffers one packet and
// replays it with the first k bytes restored as enc[i] - enc[L-k+i].
module tail_sum_decoder
    import tail_sum_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        en,
    input  logic [15:0] config_input,
    input  logic [7:0]  s_axis_data,
    input  logic        s_axis_valid,
    input  logic        s_axis_last,
    output logic        s_axis_ready,
    output logic [7:0]  m_axis_data,
    output logic        m_axis_valid,
    output logic        m_axis_last,
    input  logic        m_axis_ready,
    output logic        busy,
    output logic        len_err
);
    typedef logic [AW:0] cnt_t;

    state_e     state_q, state_d;
    cnt_t       wr_cnt_q, wr_cnt_d, rd_idx_q, rd_idx_d, pkt_len_q, pkt_len_d;
    logic [7:0] len_q, len_d, k_q, k_d, k_eff_q, k_eff_d;
    logic [7:0] m_data_q, m_data_d;
    logic       ovf_q, ovf_d, len_err_q, len_err_d;
    logic       m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [7:0] cur_len, cur_k, head_byte, tail_byte;
    cnt_t       new_len;
    logic       full, k_ok, load, we;

    // Config is taken live on the first beat so a 1-byte packet sees it too.
    assign cur_len = (wr_cnt_q == '0) ? config_input[CFG_LEN_MSB:CFG_LEN_LSB] : len_q;
    assign cur_k   = (wr_cnt_q == '0) ? config_input[CFG_K_MSB:CFG_K_LSB] : k_q;
    assign full    = wr_cnt_q[AW];
    assign new_len = full ? cnt_t'(DEPTH) : wr_cnt_q + cnt_t'(1);
    assign k_ok    = cnt_t'({cur_k, 1'b0}) <= new_len;
    assign load    = !m_valid_q || m_axis_ready;
    assign we      = (state_q == RECV) && s_axis_valid && !full;

    tsd_pkt_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk     (clk),
        .we      (we),
        .waddr   (AW'(wr_cnt_q)),
        .wdata   (s_axis_data),
        .raddr_a (AW'(rd_idx_q)),
        .raddr_b (AW'(pkt_len_q - cnt_t'(k_eff_q) + rd_idx_q)),
        .rdata_a (head_byte),
        .rdata_b (tail_byte)
    );

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_idx_d  = rd_idx_q;
        pkt_len_d = pkt_len_q;
        len_d     = len_q;
        k_d       = k_q;
        k_eff_d   = k_eff_q;
        ovf_d     = ovf_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        len_err_d = 1'b0;
        if (state_q == RECV) begin
            if (s_axis_valid) begin
                wr_cnt_d = full ? wr_cnt_q : wr_cnt_q + cnt_t'(1);
                ovf_d    = ovf_q || full;
                len_d    = cur_len;
                k_d      = cur_k;
                if (s_axis_last) begin
                    state_d   = SEND;
                    pkt_len_d = new_len;
                    k_eff_d   = k_ok ? cur_k : '0;
                    len_err_d = (new_len != cnt_t'(cur_len)) || !k_ok || ovf_q || full;
                end
            end
        end else if (m_valid_q && m_axis_ready && m_last_q) begin
            state_d   = RECV;
            wr_cnt_d  = '0;
            rd_idx_d  = '0;
            ovf_d     = 1'b0;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end else if (load) begin
            m_valid_d = rd_idx_q < pkt_len_q;
            if (rd_idx_q < pkt_len_q) begin
                m_data_d = (rd_idx_q < cnt_t'(k_eff_q)) ? head_byte - tail_byte : head_byte;
                m_last_d = rd_idx_q == pkt_len_q - cnt_t'(1);
                rd_idx_d = rd_idx_q + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge en) begin
        if (!en) begin
            state_q   <= RECV;
            wr_cnt_q  <= '0;
            rd_idx_q  <= '0;
            pkt_len_q <= '0;
            len_q     <= '0;
            k_q       <= '0;
            k_eff_q   <= '0;
            ovf_q     <= 1'b0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_idx_q  <= rd_idx_d;
            pkt_len_q <= pkt_len_d;
            len_q     <= len_d;
            k_q       <= k_d;
            k_eff_q   <= k_eff_d;
            ovf_q     <= ovf_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            len_err_q <= len_err_d;
        end
    end

    assign s_axis_ready = state_q == RECV;
    assign busy         = state_q == SEND;
    assign m_axis_data  = m_data_q;
    assign m_axis_valid = m_valid_q;
    assign m_axis_last  = m_last_q;
    assign len_err      = len_err_q;
endmodule

// File: tb/tb_tail_sum_decoder.sv
// tb_tail_sum_decoder: directed and randomized packets checked against an
// encoder-based reference and a rule-level decode model.
module tb_tail_sum_decoder;
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        en;
    logic [15:0] config_input = '0;
    logic [7:0]  s_axis_data = '0;
    logic        s_axis_valid = 1'b0, s_axis_last = 1'b0, m_axis_ready = 1'b0;
    logic        s_axis_ready, m_axis_valid, m_axis_last, busy, len_err;
    logic [7:0]  m_axis_data;
    int          vectors = 0, miscompares = 0, err_pulses = 0;

    tail_sum_decoder dut (
        .clk          (clk),
        .en           (en),
        .config_input (config_input),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_last  (s_axis_last),
        .s_axis_ready (s_axis_ready),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_last  (m_axis_last),
        .m_axis_ready (m_axis_ready),
        .busy         (busy),
        .len_err      (len_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (en && len_err) err_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic bq_t encode(input bq_t o, input int k);
        bq_t e = o;
        for (int i = 0; i < k; i++) e[i] = o[i] + o[o.size() - k + i];
        return e;
    endfunction

    function automatic bq_t decode_model(input bq_t enc, input int k);
        int  l  = enc.size() > 256 ? 256 : enc.size();
        int  ke = (2 * k <= l) ? k : 0;
        bq_t o;
        for (int i = 0; i < l; i++) o.push_back(i < ke ? 8'(enc[i] - enc[l - ke + i]) : enc[i]);
        return o;
    endfunction

    function automatic bit err_model(input int n, input int len, input int k);
        int l = n > 256 ? 256 : n;
        return (l != len) || (2 * k > l) || (n > 256);
    endfunction

    task automatic send(input bq_t d, input int len, input int k, input bit gaps, input bit with_last);
        err_pulses = 0;
        config_input = {8'(len), 8'(k)};
        foreach (d[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_axis_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_axis_valid = 1'b1;
            s_axis_data  = d[i];
            s_axis_last  = with_last && (i == d.size() - 1);
            chk("s_ready_recv", 32'(s_axis_ready), 1);
            @(posedge clk); #1;
            config_input = 16'($urandom);
        end
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
    endtask

    task automatic recv(input bq_t exp, input bit exp_err, input int mode, input string tag);
        int         idx = 0, cyc = 0, first_v = -1;
        logic       stall = 1'b0, hold_l = 1'b0;
        logic [7:0] hold_d = '0;
        while (idx < exp.size() && cyc < 3000) begin
            m_axis_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            chk({tag, "_busy"}, 32'(busy), 1);
            chk({tag, "_s_ready_send"}, 32'(s_axis_ready), 0);
            if (stall) begin
                chk({tag, "_hold_valid"}, 32'(m_axis_valid), 1);
                chk({tag, "_hold_data"}, 32'(m_axis_data), 32'(hold_d));
                chk({tag, "_hold_last"}, 32'(m_axis_last), 32'(hold_l));
            end
            if (m_axis_valid && first_v < 0) first_v = cyc;
            if (m_axis_valid && m_axis_ready) begin
                chk($sformatf("%s_data[%0d]", tag, idx), 32'(m_axis_data), 32'(exp[idx]));
                chk($sformatf("%s_last[%0d]", tag, idx), 32'(m_axis_last), 32'(idx == exp.size() - 1));
                idx++;
            end
            stall  = m_axis_valid && !m_axis_ready;
            hold_d = m_axis_data;
            hold_l = m_axis_last;
            @(posedge clk); #1;
            cyc++;
        end
        m_axis_ready = 1'b0;
        chk({tag, "_beats"}, 32'(idx), 32'(exp.size()));
        chk({tag, "_latency"}, 32'(first_v), 1);
        chk({tag, "_len_err"}, 32'(err_pulses), 32'(exp_err));
        chk({tag, "_s_ready_after"}, 32'(s_axis_ready), 1);
        chk({tag, "_valid_after"}, 32'(m_axis_valid), 0);
        chk({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    initial begin
        bq_t basic = '{8'd5, 8'd7, 8'd9, 8'd11, 8'd13, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        bq_t plain = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        bq_t wrap_in  = '{8'd44, 8'd0, 8'd0, 8'd0, 8'd0, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0};
        bq_t wrap_out = '{8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0};
        bq_t short_pkt = '{8'd5, 8'd7, 8'd9, 8'd11, 8'd13, 8'd5, 8'd6};
        bq_t one = '{8'hAB};
        bq_t big, orig, enc;
        en = 1'b1;
        #2 en = 1'b0;
        #1;
        chk("rst_valid", 32'(m_axis_valid), 0);
        chk("rst_last", 32'(m_axis_last), 0);
        chk("rst_data", 32'(m_axis_data), 0);
        chk("rst_len_err", 32'(len_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_s_ready", 32'(s_axis_ready), 1);
        repeat (2) @(posedge clk);
        #1 en = 1'b1;
        @(posedge clk); #1;

        send(basic, 10, 5, 0, 1);
        recv(plain, 0, 0, "basic");
        send(wrap_in, 10, 5, 0, 1);
        recv(wrap_out, 0, 0, "wrap");
        send(basic, 10, 5, 1, 1);
        recv(plain, 0, 1, "backpressure");
        send(short_pkt, 10, 5, 0, 1);
        recv(short_pkt, 1, 0, "short");
        send(one, 1, 0, 0, 1);
        recv(one, 0, 2, "single");
        send(one, 1, 1, 0, 1);
        recv(one, 1, 0, "single_k1");

        for (int i = 0; i < 260; i++) big.push_back(8'($urandom));
        send(big, 4, 0, 0, 1);
        recv(big[0:255], 1, 0, "overflow");

        send(basic[0:3], 10, 5, 0, 0);
        en = 1'b0;
        #1;
        chk("rst_recv_valid", 32'(m_axis_valid), 0);
        @(posedge clk); #1 en = 1'b1;
        @(posedge clk); #1;
        send(basic, 10, 5, 0, 1);
        recv(plain, 0, 0, "after_rst_recv");

        send(basic, 10, 5, 0, 1);
        m_axis_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_send_pre_valid", 32'(m_axis_valid), 1);
        en = 1'b0;
        #1;
        chk("rst_send_valid", 32'(m_axis_valid), 0);
        chk("rst_send_data", 32'(m_axis_data), 0);
        chk("rst_send_busy", 32'(busy), 0);
        chk("rst_send_s_ready", 32'(s_axis_ready), 1);
        @(posedge clk); #1 en = 1'b1;
        repeat (6) begin
            chk("rst_no_residue", 32'(m_axis_valid), 0);
            @(posedge clk); #1;
        end
        m_axis_ready = 1'b0;
        send(basic, 10, 5, 0, 1);
        recv(plain, 0, 0, "after_rst_send");

        for (int t = 0; t < 10; t++) begin
            int l = $urandom_range(2, 48);
            int k = $urandom_range(0, l / 2);
            orig = {};
            for (int i = 0; i < l; i++) orig.push_back(8'($urandom));
            enc = encode(orig, k);
            send(enc, l, k, 1, 1);
            recv(orig, 0, $urandom_range(0, 2), $sformatf("rnd%0d", t));
        end
        for (int t = 0; t < 8; t++) begin
            int n   = $urandom_range(1, 24);
            int k   = $urandom_range(0, 15);
            int len = $urandom_range(0, 1) ? n : $urandom_range(1, 24);
            enc = {};
            for (int i = 0; i < n; i++) enc.push_back(8'($urandom));
            send(enc, len, k, 1, 1);
            recv(decode_model(enc, k), err_model(n, len, k), $urandom_range(0, 2), $sformatf("mix%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
